// File: rtl/rr_burst_scheduler.sv
// Round-robin burst scheduler: locks one shared burst resource to a single requester per burst.
// Latency: grant one cycle after req is seen in IDLE; at least two grant-free cycles between bursts.
// Backpressure: beats advance only on beat_valid && beat_ready; the owner keeps the grant until
//   its last beat is accepted or it drops req (abort).
// Ports:
//   clk, resetN     - clock (posedge) and asynchronous active-low reset
//   req[N]          - per-requester request, held for the whole burst
//   len[N*LEN_W]    - per-requester burst length minus one, requester i at [i*LEN_W +: LEN_W]
//   beat_valid/ready- beat handshake between the owner and the resource
//   grant[N]        - registered one-hot grant (or 0); owner/busy describe the current lock
//   beats_left      - remaining beats minus one for the current burst
//   done/abort      - one-cycle pulses on burst completion / owner dropping req mid-burst
module rr_burst_scheduler #(
  parameter int N     = 3,
  parameter int LEN_W = 4
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic [N-1:0]         req,
  input  logic [N*LEN_W-1:0]   len,
  input  logic                 beat_valid,
  input  logic                 beat_ready,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic [LEN_W-1:0]     beats_left,
  output logic                 done,
  output logic                 abort
);

  localparam int PW = $clog2(N);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_TURN  = 2'd2;

  logic [1:0]       state;
  logic [PW-1:0]    pointer;

  logic             win_found;
  logic [PW-1:0]    win_idx;
  logic [LEN_W-1:0] win_len;

  logic             beat_acc;
  logic             last_beat;
  logic             owner_drop;

  // Search upward from pointer+1, wrapping modulo N, so indices >= N are never produced
  // and the most recent winner is considered last.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    win_len   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(pointer) + k) % N;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = PW'(idx);
        win_len   = len[idx*LEN_W +: LEN_W];
      end
    end
  end

  assign beat_acc   = beat_valid && beat_ready;
  assign last_beat  = beat_acc && (beats_left == '0);
  assign owner_drop = !req[owner];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= ST_IDLE;
      pointer    <= PW'(N - 1);
      grant      <= '0;
      owner      <= '0;
      busy       <= 1'b0;
      beats_left <= '0;
      done       <= 1'b0;
      abort      <= 1'b0;
    end else begin
      done  <= 1'b0;
      abort <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            grant      <= {{(N-1){1'b0}}, 1'b1} << win_idx;
            owner      <= win_idx;
            busy       <= 1'b1;
            beats_left <= win_len;
            pointer    <= win_idx;
            state      <= ST_BURST;
          end
        end
        ST_BURST: begin
          // Completion wins over a simultaneous req drop.
          if (last_beat) begin
            grant <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_TURN;
          end else begin
            if (beat_acc) begin
              beats_left <= beats_left - 1'b1;
            end
            if (owner_drop) begin
              grant <= '0;
              busy  <= 1'b0;
              abort <= 1'b1;
              state <= ST_TURN;
            end
          end
        end
        ST_TURN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_burst_scheduler.sv
// Bench for rr_burst_scheduler: directed scenarios with a scoreboard of grant/done/abort events.
// Ports of the DUT are driven one time unit after the rising edge and sampled either then or on
// the falling edge.
module tb_rr_burst_scheduler;

  localparam int N     = 3;
  localparam int LEN_W = 4;

  logic                 clk;
  logic                 resetN;
  logic [N-1:0]         req;
  logic [N*LEN_W-1:0]   len;
  logic                 beat_valid;
  logic                 beat_ready;
  logic [N-1:0]         grant;
  logic [$clog2(N)-1:0] owner;
  logic                 busy;
  logic [LEN_W-1:0]     beats_left;
  logic                 done;
  logic                 abort;

  int n_checks = 0;
  int n_errors = 0;
  int sb[$];
  logic [N-1:0] prev_grant = '0;

  rr_burst_scheduler #(.N(N), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .resetN     (resetN),
    .req        (req),
    .len        (len),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .grant      (grant),
    .owner      (owner),
    .busy       (busy),
    .beats_left (beats_left),
    .done       (done),
    .abort      (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Event encoding: kind*256 + grant; kind 0 = grant rise, 1 = done, 2 = abort.
  task automatic expect_ev(input int kind, input int g);
    sb.push_back(kind * 256 + g);
  endtask

  task automatic got_ev(input int kind, input int g);
    int ev;
    int exp;
    ev = kind * 256 + g;
    if (sb.size() == 0) begin
      chk("sb_extra", ev, 0);
    end else begin
      exp = sb.pop_front();
      chk("sb_event", ev, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int l0, input int l1, input int l2);
    len = {LEN_W'(l2), LEN_W'(l1), LEN_W'(l0)};
  endtask

  // Invariants and scoreboard monitor.
  always @(negedge clk) begin
    if (!resetN) begin
      prev_grant = '0;
    end else begin
      chk("onehot0", 32'($onehot0(grant)), 1);
      chk("grant_iff_busy", 32'((grant != '0) == busy), 1);
      chk("done_and_abort", 32'(done && abort), 0);
      if (done || abort) got_ev(done ? 1 : 2, 0);
      if (grant != '0 && prev_grant == '0) got_ev(0, int'(grant));
      prev_grant = grant;
    end
  end

  initial begin
    int exp_bl;
    int fin;
    resetN     = 1'b0;
    req        = '0;
    len        = '0;
    beat_valid = 1'b0;
    beat_ready = 1'b0;
    repeat (2) tick();

    // Reset state.
    chk("rst_grant", grant, 0);
    chk("rst_owner", owner, 0);
    chk("rst_busy", busy, 0);
    chk("rst_beats_left", beats_left, 0);
    chk("rst_done", done, 0);
    chk("rst_abort", abort, 0);

    // Single requester, len 2, always ready.
    resetN = 1'b1;
    req = 3'b001;
    set_len(2, 0, 0);
    beat_valid = 1'b1;
    beat_ready = 1'b1;
    expect_ev(0, 1);
    expect_ev(1, 0);
    tick();
    chk("t1_grant_lat", grant, 3'b001);
    chk("t1_bl0", beats_left, 2);
    tick();
    chk("t1_bl1", beats_left, 1);
    tick();
    chk("t1_bl2", beats_left, 0);
    chk("t1_no_early_done", done, 0);
    tick();
    chk("t1_done", done, 1);
    chk("t1_grant_off", grant, 0);
    req = '0;
    tick();
    chk("t1_done_1cyc", done, 0);
    tick();

    // All three requesting, len 0: rotation from a fresh reset.
    resetN = 1'b0;
    req = 3'b111;
    set_len(0, 0, 0);
    tick();
    resetN = 1'b1;
    expect_ev(0, 1); expect_ev(1, 0);
    expect_ev(0, 2); expect_ev(1, 0);
    expect_ev(0, 4); expect_ev(1, 0);
    expect_ev(0, 1); expect_ev(1, 0);
    tick();
    chk("t2_first", grant, 3'b001);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("t2_done", done, 1);
      tick();
      chk("t2_gap_grant", grant, 0);
      chk("t2_gap_done", done, 0);
      tick();
      chk("t2_next", grant, 32'(1 << (i % 3)));
    end
    tick();
    chk("t2_last_done", done, 1);
    req = '0;
    repeat (2) tick();

    // Requester 1, len 5, ready toggling: beats_left moves only on accepted beats.
    req = 3'b010;
    set_len(0, 5, 0);
    beat_valid = 1'b1;
    beat_ready = 1'b0;
    expect_ev(0, 2);
    expect_ev(1, 0);
    tick();
    chk("t3_grant", grant, 3'b010);
    chk("t3_bl_init", beats_left, 5);
    exp_bl = 5;
    fin = 0;
    for (int c = 0; c < 20 && fin == 0; c++) begin
      beat_ready = (c % 2 == 0);
      tick();
      if (beat_ready) begin
        if (exp_bl == 0) fin = 1;
        else exp_bl--;
      end
      if (fin != 0) begin
        chk("t3_done", done, 1);
      end else begin
        chk("t3_bl", beats_left, exp_bl);
        chk("t3_no_done", done, 0);
      end
    end
    req = '0;
    beat_ready = 1'b1;
    repeat (2) tick();

    // Requester 2, len 7, drops req after two beats.
    req = 3'b100;
    set_len(0, 0, 7);
    expect_ev(0, 4);
    expect_ev(2, 0);
    tick();
    chk("t4_grant", grant, 3'b100);
    chk("t4_bl_init", beats_left, 7);
    tick();
    tick();
    chk("t4_bl_after2", beats_left, 5);
    req = '0;
    tick();
    chk("t4_abort", abort, 1);
    chk("t4_no_done", done, 0);
    chk("t4_grant_off", grant, 0);
    chk("t4_busy_off", busy, 0);
    // Pointer now at 2: requester 0 must beat requester 1.
    req = 3'b011;
    set_len(0, 0, 0);
    expect_ev(0, 1);
    expect_ev(1, 0);
    tick();
    chk("t4_abort_1cyc", abort, 0);
    chk("t4_turn_grant", grant, 0);
    tick();
    chk("t4_wrap_grant", grant, 3'b001);
    tick();
    chk("t4_wrap_done", done, 1);
    req = '0;
    repeat (2) tick();

    // Last beat coincides with req drop: done wins.
    req = 3'b010;
    set_len(0, 1, 0);
    expect_ev(0, 2);
    expect_ev(1, 0);
    tick();
    chk("t5_grant", grant, 3'b010);
    tick();
    chk("t5_bl", beats_left, 0);
    req = '0;
    tick();
    chk("t5_done", done, 1);
    chk("t5_abort", abort, 0);
    repeat (2) tick();

    // Reset mid-burst.
    req = 3'b100;
    set_len(0, 0, 5);
    expect_ev(0, 4);
    tick();
    chk("t6_grant", grant, 3'b100);
    tick();
    tick();
    chk("t6_bl3", beats_left, 3);
    resetN = 1'b0;
    #1;
    chk("t6_rst_grant", grant, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_bl", beats_left, 0);
    req = 3'b010;
    set_len(0, 0, 0);
    expect_ev(0, 2);
    expect_ev(1, 0);
    tick();
    resetN = 1'b1;
    tick();
    chk("t6_post_grant", grant, 3'b010);
    tick();
    chk("t6_post_done", done, 1);
    req = '0;
    repeat (3) tick();

    chk("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_burst_scheduler.md
Name: rr_burst_scheduler

Overview:
Shares one burst-capable resource (e.g. a memory port) between N requesters. Round-robin arbitration with a rotating priority pointer. The winner holds a locked grant for a whole burst, whose length is latched at grant time, and releases after the last beat or on abort. Sits between the requester front-ends and the resource; beats handshake with valid/ready.

Parameters:
N, 3, number of requesters (2..8)
LEN_W, 4, width of per-requester burst-length field; value L means L+1 beats

Ports:
clk  input  1  system clock, all state on posedge
resetN  input  1  asynchronous active-low reset
req  input  N  per-requester request; must stay high for the burst
len  input  N*LEN_W  burst length minus one; requester i uses bits [i*LEN_W +: LEN_W]
beat_valid  input  1  owner presents a beat (already muxed by owner)
beat_ready  input  1  resource accepts a beat
grant  output  N  one-hot registered grant, or 0
owner  output  $clog2(N)  index of current owner, valid while busy
busy  output  1  resource is locked to an owner
beats_left  output  LEN_W  remaining beats minus one, for the current burst
done  output  1  one-cycle pulse after the last beat is accepted
abort  output  1  one-cycle pulse when the owner drops req mid-burst

Behaviour:
- Reset (async, resetN low): grant=0, owner=0, busy=0, beats_left=0, done=0, abort=0, pointer=N-1 (requester 0 has first priority), state=IDLE. Reset mid-burst kills the burst immediately with no done or abort pulse.
- States: IDLE, BURST, TURN.
- IDLE:
  - If req!=0, pick the winner: the first requester with req set, searching upward from pointer+1 and wrapping modulo N.
  - Next edge: grant=onehot(winner), owner=winner, busy=1, beats_left=len[winner], pointer=winner, state=BURST.
  - Grant latency is 1 cycle from req seen in IDLE.
- BURST:
  - A beat is accepted when beat_valid&&beat_ready. If beats_left>0, beats_left decrements by 1.
  - If the accepted beat occurs with beats_left==0, it is the last beat. Next edge: grant=0, busy=0, done=1 for one cycle, state=TURN.
  - If req[owner] drops before the last beat: next edge grant=0, busy=0, abort=1 for one cycle, state=TURN. Any beat accepted in that same cycle is still counted, but done is not pulsed.
  - If the last beat and the req drop happen in the same cycle, done takes priority and abort=0.
  - Changes to other requesters' req or len during BURST are ignored.
- TURN: exactly one idle cycle (grant=0). Then state=IDLE. Arbitration happens in the following IDLE cycle, so the minimum gap between grants is 2 cycles.
- A requester with a continuously held req is skipped until all other active requesters have been served once. No starvation.
- N not a power of two: pointer wrap is modulo N, and indices >= N are never granted.
- Single-requester case: back-to-back bursts by the same requester follow the same IDLE/BURST/TURN sequence.
- Assertions the bench checks:
  - grant is one-hot or zero.
  - grant!=0 iff busy.
  - done and abort are never high together.

Test Plan:
- Reset, req=3'b001, len0=2, beat_valid=beat_ready=1 constantly -> grant=001 one cycle after req; 3 beats accepted; done pulses on the cycle after the 3rd beat; grant=0 from that same edge.
- req=3'b111 held, all len=0, always-ready -> grant order 001, 010, 100, 001; 2-cycle gap (TURN + IDLE) between grants; each done pulse 1 cycle.
- Owner 1 granted with len1=5, beat_ready toggling 1,0,1,0 -> beats_left steps 5,4,3,2,1,0 only on accepted beats; done after the 6th accepted beat.
- Owner 2 with len2=7 drops req after 2 beats -> abort=1 for one cycle, done=0, grant=0; next arbitration starts from requester 0.
- Last beat coincides with req drop -> done=1, abort=0.
- resetN pulsed low mid-burst (beats_left=3) -> grant, busy and beats_left go 0 immediately; after release, req=3'b010 gets grant=010 on the next cycle.
